// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Latency: n/a (types, constants and an elaboration-time check only).
// Backpressure: n/a.
//
// Contents:
//   shadow_t          one in-flight writer record {valid, wr_en, is_load, dest}
//   FWD_SRC_RF        forward-select value meaning "use the register-file read"
//   hazard_params_ok  legality check for the controller parameter set
package hazard_pkg;

  // Destinations are stored zero-extended to this width so that a single
  // packed struct type serves every legal REG_ADDR_W.
  localparam int MAX_REG_ADDR_W = 8;

  localparam int FWD_SRC_RF = 0;

  typedef struct packed {
    logic                      valid;
    logic                      wr_en;
    logic                      is_load;
    logic [MAX_REG_ADDR_W-1:0] dest;
  } shadow_t;

  function automatic bit hazard_params_ok(input int reg_addr_w, input int depth,
                                          input int load_stage, input int br_stage);
    return (reg_addr_w >= 1) && (reg_addr_w <= MAX_REG_ADDR_W) &&
           (depth >= 2) && (depth <= 8) &&
           (load_stage >= 1) && (load_stage <= depth - 1) &&
           (br_stage >= 1) && (br_stage <= depth);
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Priority forward-select for one EX source operand against stages 2..DEPTH.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   src          EX source register index (zero-extended)
//   use_src      EX instruction really reads src
//   ent          shadow entries of stages 2..DEPTH
//   sel          0 = register file, k-1 = result held by stage k (youngest wins)
//   load_hazard  a matching producer is still a load that has not produced data
module fwd_prio_sel
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2
) (
  input  logic [MAX_REG_ADDR_W-1:0] src,
  input  logic                      use_src,
  input  shadow_t [DEPTH:2]         ent,
  output logic [SEL_W-1:0]          sel,
  output logic                      load_hazard
);

  // Walk from the oldest stage to the youngest so the last hit (the
  // youngest producer) is the one that sticks.
  always_comb begin
    sel         = SEL_W'(FWD_SRC_RF);
    load_hazard = 1'b0;
    for (int k = DEPTH; k >= 2; k--) begin
      if (ent[k].valid && ent[k].wr_en && use_src &&
          (src != '0) && (ent[k].dest == src)) begin
        sel = SEL_W'(k - 1);
        if (ent[k].is_load && (k <= LOAD_STAGE)) begin
          load_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline: load-use stall,
// branch flush and EX operand forward selects from a shadow writer pipeline.
// Latency: stall/bubble/flush/fwd_sel are combinational; shadow advances every edge.
// Backpressure: stall holds PC and IF/ID; stages from EX onward never stall.
//
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters
// (parameter CNT_W, ports stall_cnt/flush_cnt). Without it they do not exist.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source indices; id_use_rs/id_use_rt qualify them
//   id_wr_en, id_dest          ID writes register id_dest
//   id_is_load                 ID instruction is a load
//   br_redirect                taken branch resolved in BR_STAGE this cycle
//   stall, bubble              hold PC + IF/ID, zero ID->EX controls
//   flush                      squash IF/ID and stages 1..BR_STAGE-1
//   fwd_sel_a, fwd_sel_b       EX operand source: 0 = regfile, k = stage k+1 result
//   ex_valid                   shadow EX entry valid
//   stall_cnt, flush_cnt       saturating event counters (HAZ_PERF_CNT_EN)
module pipe_hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int BR_STAGE   = 2,
`ifdef HAZ_PERF_CNT_EN
  parameter int CNT_W      = 16,
`endif
  localparam int SEL_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_is_load,
  input  logic                  br_redirect,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  ex_valid
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  if (!hazard_params_ok(REG_ADDR_W, DEPTH, LOAD_STAGE, BR_STAGE)) begin : g_param_err
    $error("pipe_hazard_fwd_ctrl: illegal REG_ADDR_W/DEPTH/LOAD_STAGE/BR_STAGE");
  end

  // s[1] = EX ... s[DEPTH] = last tracked stage.
  shadow_t [DEPTH:1]     s;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_use_rs;
  logic                  ex_use_rt;

  logic load_use;
  logic admit;
  logic load_haz_a;
  logic load_haz_b;

  function automatic logic src_hit(input shadow_t e, input logic [REG_ADDR_W-1:0] src,
                                   input logic use_src);
    return e.valid && e.wr_en && use_src && (src != '0) &&
           (e.dest == MAX_REG_ADDR_W'(src));
  endfunction

  // Loads whose data is not ready until the end of LOAD_STAGE block any ID
  // consumer while they sit in stages 1..LOAD_STAGE-1.
  always_comb begin
    load_use = 1'b0;
    for (int k = 1; k < LOAD_STAGE; k++) begin
      if (s[k].is_load &&
          (src_hit(s[k], id_rs, id_use_rs) || src_hit(s[k], id_rt, id_use_rt))) begin
        load_use = 1'b1;
      end
    end
  end

  // A redirect squashes the ID instruction anyway, so it overrides the stall.
  assign flush    = br_redirect;
  assign stall    = id_valid && !flush && load_use;
  assign bubble   = stall;
  assign admit    = id_valid && !stall && !flush;
  assign ex_valid = s[1].valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
    end else begin
      // Younger-than-branch entries moving into 2..BR_STAGE are wrong-path.
      for (int k = DEPTH; k >= 2; k--) begin
        s[k] <= (flush && (k <= BR_STAGE)) ? '0 : s[k-1];
      end
      if (admit) begin
        s[1] <= '{valid:   1'b1,
                  wr_en:   id_wr_en,
                  is_load: id_is_load,
                  dest:    MAX_REG_ADDR_W'(id_dest)};
      end else begin
        s[1] <= '0;
      end
      // Source copies are cleared with an empty EX slot so a bubble never
      // produces a non-zero forward select.
      ex_rs     <= admit ? id_rs : '0;
      ex_rt     <= admit ? id_rt : '0;
      ex_use_rs <= admit && id_use_rs;
      ex_use_rt <= admit && id_use_rt;
    end
  end

  fwd_prio_sel #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .SEL_W      (SEL_W)
  ) u_fwd_a (
    .src         (MAX_REG_ADDR_W'(ex_rs)),
    .use_src     (ex_use_rs),
    .ent         (s[DEPTH:2]),
    .sel         (fwd_sel_a),
    .load_hazard (load_haz_a)
  );

  fwd_prio_sel #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .SEL_W      (SEL_W)
  ) u_fwd_b (
    .src         (MAX_REG_ADDR_W'(ex_rt)),
    .use_src     (ex_use_rt),
    .ent         (s[DEPTH:2]),
    .sel         (fwd_sel_b),
    .load_hazard (load_haz_b)
  );

  // A consumer in EX must never depend on a load whose data does not exist yet.
  always_comb begin
    if (rst_n) begin
      assert (!(ex_valid && (load_haz_a || load_haz_b)));
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd_ctrl.sv
// Testbench for pipe_hazard_fwd_ctrl: directed scenarios plus random traffic
// compared each cycle against a timestamp-based model of in-flight instructions.
module tb_pipe_hazard_fwd_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int BR_STAGE   = 2;
  localparam int SEL_W      = $clog2(DEPTH);

  logic                  clk;
  logic                  rst_n;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  id_wr_en;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_is_load;
  logic                  br_redirect;
  logic                  stall;
  logic                  bubble;
  logic                  flush;
  logic [SEL_W-1:0]      fwd_sel_a;
  logic [SEL_W-1:0]      fwd_sel_b;
  logic                  ex_valid;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        sat_stall, sat_bubble, sat_flush, sat_ex_valid;
  logic [SEL_W-1:0] sat_fwd_a, sat_fwd_b;
  logic [1:0]  sat_stall_cnt;
  logic [1:0]  sat_flush_cnt;
`endif

  pipe_hazard_fwd_ctrl #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .BR_STAGE   (BR_STAGE)
`ifdef HAZ_PERF_CNT_EN
    , .CNT_W    (16)
`endif
  ) dut (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid),
    .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .id_wr_en (id_wr_en), .id_dest (id_dest), .id_is_load (id_is_load),
    .br_redirect (br_redirect), .stall (stall), .bubble (bubble), .flush (flush),
    .fwd_sel_a (fwd_sel_a), .fwd_sel_b (fwd_sel_b), .ex_valid (ex_valid)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
`endif
  );

`ifdef HAZ_PERF_CNT_EN
  pipe_hazard_fwd_ctrl #(
    .REG_ADDR_W (REG_ADDR_W), .DEPTH (DEPTH), .LOAD_STAGE (LOAD_STAGE),
    .BR_STAGE (BR_STAGE), .CNT_W (2)
  ) dut_sat (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid),
    .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
    .id_wr_en (id_wr_en), .id_dest (id_dest), .id_is_load (id_is_load),
    .br_redirect (br_redirect), .stall (sat_stall), .bubble (sat_bubble), .flush (sat_flush),
    .fwd_sel_a (sat_fwd_a), .fwd_sel_b (sat_fwd_b), .ex_valid (sat_ex_valid),
    .stall_cnt (sat_stall_cnt), .flush_cnt (sat_flush_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every admitted instruction remembers the cycle it
  // entered EX; its stage is simply how many cycles have passed since then.
  typedef struct {
    int ex_cyc;
    bit wr;
    int dest;
    bit ld;
    bit killed;
    int rs;
    bit urs;
    int rt;
    bit urt;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  bit   e_stall = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int stage_of(input rec_t r);
    return cyc - r.ex_cyc + 1;
  endfunction

  function automatic bit hits(input int d, input int src, input bit u);
    return u && (src != 0) && (d == src);
  endfunction

  function automatic bit m_stall();
    if (!id_valid || br_redirect) return 1'b0;
    foreach (q[i]) begin
      int st = stage_of(q[i]);
      if (!q[i].killed && q[i].ld && q[i].wr && (st >= 1) && (st < LOAD_STAGE) &&
          (hits(q[i].dest, int'(id_rs), id_use_rs) || hits(q[i].dest, int'(id_rt), id_use_rt)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int src, input bit u);
    int best = 0;
    foreach (q[i]) begin
      int st = stage_of(q[i]);
      if (!q[i].killed && q[i].wr && (st >= 2) && (st <= DEPTH) && hits(q[i].dest, src, u))
        if ((best == 0) || (st - 1 < best)) best = st - 1;
    end
    return best;
  endfunction

  task automatic model_check();
    bit   have_c = 1'b0;
    rec_t c;
    int   fa = 0;
    int   fb = 0;
    e_stall = m_stall();
    foreach (q[i]) begin
      if (!q[i].killed && (stage_of(q[i]) == 1)) begin
        have_c = 1'b1;
        c = q[i];
      end
    end
    if (have_c) begin
      fa = m_fwd(c.rs, c.urs);
      fb = m_fwd(c.rt, c.urt);
    end
    chk("stall",     int'(stall),     int'(e_stall));
    chk("bubble",    int'(bubble),    int'(e_stall));
    chk("flush",     int'(flush),     int'(br_redirect));
    chk("fwd_sel_a", int'(fwd_sel_a), fa);
    chk("fwd_sel_b", int'(fwd_sel_b), fb);
    chk("ex_valid",  int'(ex_valid),  int'(have_c));
  endtask

  task automatic model_advance();
    if (br_redirect) begin
      foreach (q[i]) begin
        int st = stage_of(q[i]);
        if ((st >= 1) && (st <= BR_STAGE - 1)) q[i].killed = 1'b1;
      end
    end
    if (id_valid && !e_stall && !br_redirect)
      q.push_back('{cyc + 1, id_wr_en, int'(id_dest), id_is_load, 1'b0,
                    int'(id_rs), id_use_rs, int'(id_rt), id_use_rt});
    cyc++;
    while ((q.size() > 0) && (stage_of(q[0]) > DEPTH)) void'(q.pop_front());
  endtask

  // One ID cycle: inputs change after the rising edge, outputs are sampled
  // 1 time unit later and the model is advanced for the coming edge.
  task automatic step(input bit v, input bit we, input int dest, input bit ld,
                      input int rs, input bit urs, input int rt, input bit urt,
                      input bit br);
    @(negedge clk);
    id_valid    = v;
    id_wr_en    = we;
    id_dest     = REG_ADDR_W'(dest);
    id_is_load  = ld;
    id_rs       = REG_ADDR_W'(rs);
    id_use_rs   = urs;
    id_rt       = REG_ADDR_W'(rt);
    id_use_rt   = urt;
    br_redirect = br;
    #1;
    model_check();
    model_advance();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_use_pair();
    step(1, 1, 4, 1, 0, 0, 0, 0, 0);
    step(1, 1, 9, 0, 4, 1, 0, 0, 0);
    step(1, 1, 9, 0, 4, 1, 0, 0, 0);
  endtask

  int r_dest, r_rs, r_rt;
  bit r_v, r_we, r_ld, r_urs, r_urt, r_br;

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_dest = '0; id_is_load = 0; br_redirect = 0;
    #1;
    chk("reset_stall",    int'(stall),     0);
    chk("reset_bubble",   int'(bubble),    0);
    chk("reset_flush",    int'(flush),     0);
    chk("reset_fwd_a",    int'(fwd_sel_a), 0);
    chk("reset_fwd_b",    int'(fwd_sel_b), 0);
    chk("reset_ex_valid", int'(ex_valid),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ALU -> ALU back to back
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 2, 1, 0, 0, 0);
    chk("alu_alu_stall", int'(stall), 0);
    nop();
    chk("alu_alu_fwd_a", int'(fwd_sel_a), 1);

    // Producer, unrelated op, consumer on rt
    step(1, 1, 5, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 1, 1, 0, 0, 0);
    step(1, 1, 8, 0, 0, 0, 5, 1, 0);
    nop();
    chk("gap1_fwd_b", int'(fwd_sel_b), 2);

    // Load-use: one stall cycle, then forward from WB
    step(1, 1, 4, 1, 0, 0, 0, 0, 0);
    step(1, 1, 6, 0, 4, 1, 0, 0, 0);
    chk("ldu_stall",  int'(stall),  1);
    chk("ldu_bubble", int'(bubble), 1);
    step(1, 1, 6, 0, 4, 1, 0, 0, 0);
    chk("ldu_release", int'(stall), 0);
    nop();
    chk("ldu_fwd_a", int'(fwd_sel_a), 2);

    // r0 is never a dependency, even behind a load
    step(1, 1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 6, 0, 0, 1, 0, 1, 0);
    chk("r0_stall", int'(stall), 0);
    nop();
    chk("r0_fwd_a", int'(fwd_sel_a), 0);

    // Flush beats stall and kills the wrong-path load
    step(1, 1, 4, 1, 0, 0, 0, 0, 0);
    step(1, 1, 6, 0, 4, 1, 0, 0, 1);
    chk("flush_no_stall", int'(stall), 0);
    chk("flush_flag",     int'(flush), 1);
    step(1, 1, 6, 0, 4, 1, 0, 0, 0);
    chk("flush_ex_valid", int'(ex_valid), 0);
    chk("flush_killed_no_stall", int'(stall), 0);
    nop();
    chk("flush_killed_no_fwd", int'(fwd_sel_a), 0);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if (!e_stall) begin
        r_v    = ($urandom_range(0, 3) != 0);
        r_we   = ($urandom_range(0, 3) != 0);
        r_dest = $urandom_range(0, 3);
        r_ld   = ($urandom_range(0, 2) == 0);
        r_rs   = $urandom_range(0, 3);
        r_urs  = ($urandom_range(0, 1) != 0);
        r_rt   = $urandom_range(0, 3);
        r_urt  = ($urandom_range(0, 1) != 0);
      end
      r_br = ($urandom_range(0, 9) == 0);
      step(r_v, r_we, r_dest, r_ld, r_rs, r_urs, r_rt, r_urt, r_br);
    end

    // Reset mid-stream with three valid entries in flight
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 2, 1, 1, 1, 0);
    step(1, 1, 6, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_ex_valid", int'(ex_valid),  1);
    chk("pre_rst_fwd_a",    int'(fwd_sel_a), 1);
    chk("pre_rst_fwd_b",    int'(fwd_sel_b), 2);
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ex_valid", int'(ex_valid),  0);
    chk("mid_rst_fwd_a",    int'(fwd_sel_a), 0);
    chk("mid_rst_fwd_b",    int'(fwd_sel_b), 0);
    chk("mid_rst_stall",    int'(stall),     0);
    q.delete();
    e_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First transaction after release is tracked normally
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 2, 1, 0, 0, 0);
    nop();
    chk("post_rst_fwd_a", int'(fwd_sel_a), 1);

`ifdef HAZ_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    q.delete();
    e_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) load_use_pair();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    chk("stall_cnt_3", int'(stall_cnt), 3);
    chk("flush_cnt_2", int'(flush_cnt), 2);
    for (int n = 0; n < 2; n++) load_use_pair();
    nop();
    chk("stall_cnt_5",   int'(stall_cnt),     5);
    chk("sat_stall_cnt", int'(sat_stall_cnt), 3);
    chk("sat_flush_cnt", int'(sat_flush_cnt), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
